fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream_pkg.sv | 24 ++
 rtl/fifo_rd_stream_if.sv | 21 ++
 rtl/fifo_rd_skid.sv | 73 +++++++
 rtl/fifo_rd_stream.sv | 85 ++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_pkg
// Shared types and defaults for the FIFO read-side drain stage.
//   occ_t        : skid-buffer occupancy (0..2)
//   level_after(): occupancy the skid buffer will have next cycle, counting the
//                  word currently in flight from the FIFO and the word leaving now
// -----------------------------------------------------------------------------
package fifo_rd_stream_pkg;

    localparam int DW_DEF      = 16;
    localparam int PKT_LEN_DEF = 8;
    localparam int CW_DEF      = 16;

    localparam int OCC_W = 2;
    typedef logic [OCC_W-1:0] occ_t;

    localparam occ_t SKID_DEPTH = 2'd2;

    // occ + infl - pop. A pop implies occ >= 1, so this never underflows.
    function automatic logic [2:0] level_after(occ_t occ, logic infl, logic pop);
        return {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
// Valid/ready stream leaving the drain stage. Signal names carry the direction
// as seen from the producer (fifo_rd_stream).
//   o_valid : stream data valid
//   i_ready : downstream ready
//   o_data  : stream data (DW bits)
//   o_last  : final beat of a packet
// Modports: master = producer, slave = consumer.
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
    parameter int DW = 16
);
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_last;

    modport master (output o_valid, output o_data, output o_last, input  i_ready);
    modport slave  (input  o_valid, input  o_data, input  o_last, output i_ready);
endinterface

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry register FIFO. The head register drives the stream data directly,
// so the output is registered and holds while the entry waits to be popped.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_push, i_din : write one word at the tail
//   i_pop         : remove the head word (only while o_occ != 0)
//   o_head        : current head word
//   o_occ         : number of stored words (0..2)
// -----------------------------------------------------------------------------
module fifo_rd_skid
    import fifo_rd_stream_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [DW-1:0] o_head,
    output occ_t          o_occ
);

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    occ_t          r_occ;

    // NOTE: both storage words are reset because the head is the visible
    // output and must read 0 out of reset; at two entries this costs nothing.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            // NOTE: non-blocking assignments so that the pop case reads the
            // pre-edge tail when shifting it into the head.
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= i_din;
                    else               r_tail <= i_din;
                    r_occ <= r_occ + occ_t'(1);
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - occ_t'(1);
                end
                2'b11: begin
                    // Occupancy unchanged: head advances, new word lands behind it.
                    if (r_occ == SKID_DEPTH) begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end else begin
                        r_head <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head = r_head;
    assign o_occ  = r_occ;

    a_occ_bound:  assert property (@(posedge i_clk) disable iff (!i_rstn)
                                   r_occ <= SKID_DEPTH);
    a_no_overrun: assert property (@(posedge i_clk) disable iff (!i_rstn)
                                   !(i_push && !i_pop && r_occ == SKID_DEPTH));
    a_no_underrun: assert property (@(posedge i_clk) disable iff (!i_rstn)
                                    !(i_pop && r_occ == 2'd0));

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain stage for an async FIFO (read clock domain). Issues a FIFO
// read whenever the FIFO is non-empty and the skid buffer will have room for
// the word one cycle later, absorbs the FIFO's one-cycle read latency, and
// presents the words as a valid/ready stream framed into PKT_LEN-beat packets.
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_fifo_empty   : FIFO empty flag
//   o_fifo_ren     : FIFO read enable (combinational; follows i_ready)
//   i_fifo_rdata   : FIFO read data, valid one cycle after a read
//   s_out          : stream master (o_valid / i_ready / o_data / o_last)
//   o_pkt_cnt      : completed packets, wraps modulo 2^CW
// PKT_LEN must lie in 1..65535.
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_ren,
    input  logic [DW-1:0]         i_fifo_rdata,
    fifo_rd_stream_if.master      s_out,
    output logic [CW-1:0]         o_pkt_cnt
);

    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    logic          r_infl;
    logic [15:0]   r_beat;
    logic [CW-1:0] r_pkt_cnt;

    logic          w_pop;
    logic          w_last;
    occ_t          w_occ;
    logic [DW-1:0] w_head;

    fifo_rd_skid #(.DW(DW)) u_skid (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_push (r_infl),
        .i_din  (i_fifo_rdata),
        .i_pop  (w_pop),
        .o_head (w_head),
        .o_occ  (w_occ)
    );

    assign w_pop  = s_out.o_valid & s_out.i_ready;
    assign w_last = (r_beat == LAST_BEAT) & s_out.o_valid;

    // Read only if the word arriving next cycle is guaranteed a slot. Counting
    // this cycle's pop lets a read go out while the buffer looks full, which is
    // what sustains one beat per cycle. Gated by reset so the read enable is
    // quiet while the block is held in reset.
    assign o_fifo_ren = i_rstn & ~i_fifo_empty &
                        (level_after(w_occ, r_infl, w_pop) < 3'd2);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_infl    <= 1'b0;
            r_beat    <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_infl <= o_fifo_ren;
            if (w_pop) begin
                if (w_last) begin
                    r_beat    <= '0;
                    r_pkt_cnt <= r_pkt_cnt + CW'(1);
                end else begin
                    r_beat    <= r_beat + 16'd1;
                end
            end
        end
    end

    assign s_out.o_valid = (w_occ != 2'd0);
    assign s_out.o_data  = w_head;
    assign s_out.o_last  = w_last;
    assign o_pkt_cnt     = r_pkt_cnt;

endmodule
